dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer for the 32-word single-port data memory (`MemRW`/`addr`/`dataW`/`dataR` interface). Requester 0 (core load/store unit) and requester 1 (debug/loader port) share the memory through a valid/ready request channel and a single-cycle response pulse. Arbitration is round-robin. The block owns the memory's `MemRW`, `addr` and `dataW` pins, so only one access ever reaches the memory per slot.

## Interface
- `ADDR_W`, default 5: word address width; the memory depth is 2^ADDR_W.
- `DATA_W`, default 32: data width.

Ports:
- `clk` in, 1: clock. All state changes on the rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `req0_valid` in, 1: requester 0 has a request.
- `req0_ready` out, 1: requester 0's request is accepted this cycle.
- `req0_we` in, 1: 1 = write, 0 = read.
- `req0_addr` in, ADDR_W: word address.
- `req0_wdata` in, DATA_W: write data.
- `rsp0_valid` out, 1: one-cycle completion pulse for requester 0.
- `rsp0_rdata` out, DATA_W: read data, qualified by `rsp0_valid`.
- `req1_*` and `rsp1_*`: identical set for requester 1.
- `mem_we` out, 1: drives the memory's `MemRW`.
- `mem_addr` out, ADDR_W: drives the memory's `addr`.
- `mem_wdata` out, DATA_W: drives the memory's `dataW`.
- `mem_rdata` in, DATA_W: the memory's combinational `dataR`.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP. Reset enters IDLE.
- **IDLE**
  - `reqN_ready` is asserted combinationally, to at most one requester: the arbitration winner among the requesters with `valid` high.
  - On a handshake (`valid & ready`), the block latches `we`, `addr`, `wdata` and the winner ID, then goes to ACCESS.
  - With no valid requester, it stays in IDLE.
- **Arbitration** uses a 1-bit `last` register (reset 1, so requester 0 wins first).
  - When both requesters are valid, the one not equal to `last` wins.
  - When one is valid, it wins.
  - `last` is updated to the winner on every handshake.
- **ACCESS** (exactly 1 cycle)
  - `mem_addr` and `mem_wdata` are driven from the latched request; `mem_we` is driven from the latched `we`.
  - Write: the memory updates at the closing edge.
  - Read: `mem_rdata` is captured into the response register at the closing edge.
  - Then go to RESP.
- **RESP** (exactly 1 cycle)
  - `rspN_valid` is high only for the latched winner.
  - `rspN_rdata` = captured data for a read, 0 for a write.
  - Then go to IDLE. There is no response backpressure; the requester must sample in this cycle.
- **Memory pins outside ACCESS:** `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **`reqN_ready`** is 0 in ACCESS and RESP.
- **Requester side:** a requester must hold `valid` and its payload stable until `ready`. The block samples the payload only on the handshake cycle.

## Timing
- Reset values: FSM IDLE, `last`=1, latched request and response data 0, all `rspN_valid`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Since IDLE is the reset state, a requester already valid during the first post-reset IDLE cycle may see `ready` high in that cycle.
- Handshake in cycle T → ACCESS in T+1 (write committed at end of T+1) → `rsp_valid` in T+2 → earliest next handshake in T+3.
- Peak throughput is one access per 3 cycles.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,…; neither requester waits more than one transaction.
- A read issued in the slot right after a write to the same address returns the new data (the write commits before the next ACCESS).
- `rst` asserted in ACCESS or RESP:
  - The next state is IDLE, with all outputs at reset values.
  - No `rsp_valid` is produced for the aborted request.
  - An in-flight write may or may not have committed. Asserting `rst` in ACCESS blocks the write only if the memory's reset also clears it; the arbiter makes no guarantee.
- `valid` dropping before `ready`: no transaction, no state change.

## Test plan
- **Single write then read:** req0 write addr 5 data 0xDEADBEEF, then req0 read addr 5.
  - Expect `req0_ready` in the IDLE cycle and `mem_we`=1 with `mem_addr`=5 in ACCESS.
  - Expect `rsp0_valid` 2 cycles after each handshake, and `rsp0_rdata`=0xDEADBEEF on the read.
- **Simultaneous requests after reset:** both valid; req0 reads addr 1, req1 writes addr 2 = 0x1234.
  - Expect req0 granted first and req1 at handshake+3.
  - Expect `rsp0_valid` and `rsp1_valid` never high together, and `mem_we` high exactly one cycle.
- **Continuous contention:** both requesters hold valid for 8 transactions.
  - Expect grant order 0,1,0,1,0,1,0,1 and handshakes exactly 3 cycles apart.
- **Write-ack data:** req1 write addr 31 = 0xFFFFFFFF.
  - Expect `rsp1_valid`=1 with `rsp1_rdata`=0.
  - A following req0 read of addr 31 returns 0xFFFFFFFF (address wrap boundary).
- **Reset mid-operation:** handshake a req0 read, assert `rst` in the ACCESS cycle.
  - Expect no `rsp0_valid`.
  - Expect `mem_we`/`mem_addr`=0 and `req0_ready` available again in the first cycle after `rst` drops.
- **Stall without valid:** hold both valids low for 10 cycles.
  - Expect the FSM to stay in IDLE, all memory pins 0, no `rsp_valid` pulses, and `last` unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter and access sequencer for a single-port data memory
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                last;
    logic                lat_we;
    logic                lat_id;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   rsp_data;
    logic                grant0;
    logic                grant1;

    // On contention the requester that did not win last time gets the slot.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last;
            grant1 = ~last;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_rdata = '0;
        rsp1_rdata = '0;
        case (state)
            S_IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_we    = lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp0_valid = ~lat_id;
                rsp1_valid = lat_id;
                rsp0_rdata = lat_id ? '0 : rsp_data;
                rsp1_rdata = lat_id ? rsp_data : '0;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Request payload is sampled only on the handshake; read data only in ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= 1'b1;
            lat_we    <= 1'b0;
            lat_id    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_data  <= '0;
        end else begin
            if (state == S_IDLE && (grant0 || grant1)) begin
                lat_id    <= grant1;
                last      <= grant1;
                lat_we    <= grant1 ? req1_we    : req0_we;
                lat_addr  <= grant1 ? req1_addr  : req0_addr;
                lat_wdata <= grant1 ? req1_wdata : req0_wdata;
            end
            if (state == S_ACCESS) begin
                rsp_data <= lat_we ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with transaction-level model
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_we;
    logic [4:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [4:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // The attached memory: combinational read, write at the clock edge.
    logic [31:0] bench_mem [32];
    assign mem_rdata = bench_mem[mem_addr];
    always @(posedge clk) if (mem_we) bench_mem[mem_addr] <= mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: phase 0 free, 1 = access slot, 2 = response slot.
    logic [31:0] ref_mem [32];
    int          m_phase = 0;
    logic        m_last  = 1'b1;
    logic        m_we, m_id;
    logic [4:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    int          mw, cw;

    function automatic int m_winner();
        if (req0_valid && req1_valid) return m_last ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_phase <= 0;
            m_last  <= 1'b1;
        end else begin
            case (m_phase)
                0: begin
                    mw = m_winner();
                    if (mw >= 0) begin
                        m_id    <= (mw == 1);
                        m_last  <= (mw == 1);
                        m_we    <= (mw == 1) ? req1_we    : req0_we;
                        m_addr  <= (mw == 1) ? req1_addr  : req0_addr;
                        m_wdata <= (mw == 1) ? req1_wdata : req0_wdata;
                        m_phase <= 1;
                    end
                end
                1: begin
                    if (m_we) ref_mem[m_addr] <= m_wdata;
                    m_rdata <= m_we ? 32'h0 : ref_mem[m_addr];
                    m_phase <= 2;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    int          n_rsp0 = 0, n_rsp1 = 0, n_memwe = 0, n_overlap = 0;
    logic [31:0] last_rsp0 = 32'h0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rsp0_valid) begin n_rsp0++; last_rsp0 = rsp0_rdata; end
            if (rsp1_valid) n_rsp1++;
            if (rsp0_valid && rsp1_valid) n_overlap++;
            if (mem_we) n_memwe++;
            if (chk_en) begin
                cw = m_winner();
                check("req0_ready", {31'h0, req0_ready}, {31'h0, (m_phase == 0 && cw == 0)});
                check("req1_ready", {31'h0, req1_ready}, {31'h0, (m_phase == 0 && cw == 1)});
                check("mem_we",    {31'h0, mem_we},   {31'h0, (m_phase == 1) && m_we});
                check("mem_addr",  {27'h0, mem_addr}, (m_phase == 1) ? {27'h0, m_addr} : 32'h0);
                check("mem_wdata", mem_wdata,         (m_phase == 1) ? m_wdata : 32'h0);
                check("rsp0_valid", {31'h0, rsp0_valid}, {31'h0, (m_phase == 2 && !m_id)});
                check("rsp1_valid", {31'h0, rsp1_valid}, {31'h0, (m_phase == 2 && m_id)});
                if (m_phase == 2)
                    check("rsp_rdata", m_id ? rsp1_rdata : rsp0_rdata, m_rdata);
            end
        end
    end

    task automatic drive(input int id, input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
        if (id == 0) begin req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; end
        else         begin req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; end
    endtask

    task automatic wait_ready(input int id, output int hcyc);
        hcyc = -100;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) begin
                hcyc = cyc;
                return;
            end
        end
        n_checks++; n_fail++;
        $display("FAIL ready_timeout: requester %0d got no ready, required within 30 cycles", id);
    endtask

    task automatic single(input int id, input logic we, input logic [4:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
        int h, r;
        rd = 32'hBAD0BAD0;
        r  = -1;
        @(posedge clk); #1;
        drive(id, 1'b1, we, a, d);
        wait_ready(id, h);
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("access_we",   {31'h0, mem_we},   {31'h0, we});
                check("access_addr", {27'h0, mem_addr}, {27'h0, a});
            end
            if ((id == 0) ? rsp0_valid : rsp1_valid) begin
                r  = cyc;
                rd = (id == 0) ? rsp0_rdata : rsp1_rdata;
                break;
            end
        end
        check("rsp_latency", r - h, 2);
    endtask

    int g_id [$];
    int g_cyc [$];

    task automatic contend(input int n, input bit hold,
                           input logic we0, input logic [4:0] a0, input logic [31:0] d0,
                           input logic we1, input logic [4:0] a1, input logic [31:0] d1);
        bit g0, g1;
        g_id.delete();
        g_cyc.delete();
        @(posedge clk); #1;
        drive(0, 1'b1, we0, a0, d0);
        drive(1, 1'b1, we1, a1, d1);
        for (int i = 0; i < n * 3 + 20; i++) begin
            @(negedge clk);
            g0 = req0_valid && req0_ready;
            g1 = req1_valid && req1_ready;
            if (g0) begin g_id.push_back(0); g_cyc.push_back(cyc); end
            if (g1) begin g_id.push_back(1); g_cyc.push_back(cyc); end
            @(posedge clk); #1;
            if (!hold && g0) req0_valid = 1'b0;
            if (!hold && g1) req1_valid = 1'b0;
            if (g_id.size() >= n) break;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("grant_count", g_id.size(), n);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [31:0] rd;
    int          h, base0, base_we, base_rsp;

    initial begin
        for (int i = 0; i < 32; i++) begin
            bench_mem[i] = 32'hA5A5_0000 + i;
            ref_mem[i]   = 32'hA5A5_0000 + i;
        end
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(1, 1'b0, 1'b0, 5'd0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready0",  {31'h0, req0_ready}, 32'h0);
        check("rst_rsp0",    {31'h0, rsp0_valid}, 32'h0);
        check("rst_rsp1",    {31'h0, rsp1_valid}, 32'h0);
        check("rst_mem_we",  {31'h0, mem_we},     32'h0);
        check("rst_mem_addr", {27'h0, mem_addr},  32'h0);
        @(posedge clk); #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Single write then read of address 5.
        single(0, 1'b1, 5'd5, 32'hDEADBEEF, rd);
        check("t1_write_ack", rd, 32'h0);
        single(0, 1'b0, 5'd5, 32'h0, rd);
        check("t1_read", rd, 32'hDEADBEEF);

        // Simultaneous requests after reset.
        do_reset();
        base_we = n_memwe;
        contend(2, 1'b0, 1'b0, 5'd1, 32'h0, 1'b1, 5'd2, 32'h1234);
        check("t2_first",   g_id[0], 0);
        check("t2_second",  g_id[1], 1);
        check("t2_spacing", g_cyc[1] - g_cyc[0], 3);
        check("t2_read",    last_rsp0, 32'hA5A5_0001);
        check("t2_we_once", n_memwe - base_we, 1);
        check("t2_mem2",    bench_mem[2], 32'h1234);

        // Continuous contention, 8 transactions.
        contend(8, 1'b1, 1'b0, 5'd7, 32'h0, 1'b0, 5'd9, 32'h0);
        for (int i = 0; i < 8 && i < g_id.size(); i++) begin
            check("t3_order", g_id[i], i % 2);
            if (i > 0) check("t3_spacing", g_cyc[i] - g_cyc[i-1], 3);
        end

        // Write acknowledge and the top address.
        single(1, 1'b1, 5'd31, 32'hFFFFFFFF, rd);
        check("t4_write_ack", rd, 32'h0);
        single(0, 1'b0, 5'd31, 32'h0, rd);
        check("t4_read31", rd, 32'hFFFFFFFF);

        // Reset during ACCESS of a read.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 5'd3, 32'h0);
        wait_ready(0, h);
        @(posedge clk); #1;
        rst = 1'b1;
        req0_valid = 1'b0;
        base0 = n_rsp0;
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b1;
        @(negedge clk);
        check("t5_ready0",   {31'h0, req0_ready}, 32'h1);
        check("t5_mem_we",   {31'h0, mem_we},     32'h0);
        check("t5_mem_addr", {27'h0, mem_addr},   32'h0);
        check("t5_no_rsp",   n_rsp0 - base0,      0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Stall with no valid requester; last winner was requester 0.
        base_rsp = n_rsp0 + n_rsp1;
        base_we  = n_memwe;
        repeat (10) @(negedge clk);
        check("t6_no_rsp", n_rsp0 + n_rsp1 - base_rsp, 0);
        check("t6_no_we",  n_memwe - base_we, 0);
        contend(2, 1'b0, 1'b0, 5'd4, 32'h0, 1'b0, 5'd6, 32'h0);
        check("t6_last_kept", g_id[0], 1);

        check("never_overlap", n_overlap, 0);
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
